asp_path_scheduler: RTL and testbench

- Sequencer/arbiter behind the stage-2 pipeline register of the ASP datapath.
- Consumes the stage-2 opcode, soft-error flag, host TX word and network RX word+tag.
- Queues accepted words per direction and shares one downstream output channel between them, round-robin, with valid/ready handshake.
- Filters RX words by a configurable local tag, drops soft-error words, and keeps saturating error/drop counters.

---
 rtl/asp_path_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_asp_path_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/asp_path_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : asp_path_scheduler                                            |
// | Brief    : Queues stage-2 TX/RX words and round-robins them onto one     |
// |            valid/ready output channel with error/overflow counters.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module asp_path_scheduler #(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              opcode_in,
    input  logic                    soft_error_in,
    input  logic [DATA_SIZE-1:0]    tx_data_in,
    input  logic [DATA_SIZE-1:0]    rx_data_in,
    input  logic [TAG_SIZE-1:0]     rx_tag_in,
    input  logic                    cfg_tag_we,
    input  logic [TAG_SIZE-1:0]     cfg_tag_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_SIZE-1:0]    out_data,
    output logic                    out_src,
    output logic [TAG_SIZE-1:0]     out_tag,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    busy
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(DEPTH);
    localparam logic [1:0]      c_op_send = 2'b01;
    localparam logic [1:0]      c_op_recv = 2'b10;
    localparam logic [1:0]      c_op_fl   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND_TX = 2'd1,
        ST_SEND_RX = 2'd2
    } state_t;

    logic [DATA_SIZE-1:0] r_tx_mem      [DEPTH];
    logic [DATA_SIZE-1:0] r_rx_mem_data [DEPTH];
    logic [TAG_SIZE-1:0]  r_rx_mem_tag  [DEPTH];
    logic [c_aw-1:0]      r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
    logic [c_aw:0]        r_tx_count, r_rx_count;
    logic [TAG_SIZE-1:0]  r_local_tag;
    logic [CNT_W-1:0]     r_err_count, r_drop_count;
    state_t               r_state;
    logic                 r_prefer_rx;
    logic                 r_out_valid;
    logic [DATA_SIZE-1:0] r_out_data;
    logic                 r_out_src;
    logic [TAG_SIZE-1:0]  r_out_tag;

    logic                 w_flush, w_tx_req, w_rx_req, w_hs;
    logic                 w_pop_tx, w_pop_rx, w_push_tx, w_push_rx;
    logic                 w_err_inc, w_drop_inc;
    logic                 w_tx_avail, w_rx_avail;
    logic [c_aw-1:0]      w_tx_hidx, w_rx_hidx;
    state_t               w_state_nxt;
    logic                 w_valid_nxt, w_src_nxt, w_prefer_rx_nxt;
    logic [DATA_SIZE-1:0] w_data_nxt;
    logic [TAG_SIZE-1:0]  w_tag_nxt;
    logic                 w_pick, w_grant_rx, w_grant_tx;

    assign w_flush  = (opcode_in == c_op_fl);
    assign w_tx_req = (opcode_in == c_op_send) & ~soft_error_in;
    assign w_rx_req = (opcode_in == c_op_recv) & ~soft_error_in & (rx_tag_in == r_local_tag);
    assign w_hs     = r_out_valid & out_ready;
    assign w_pop_tx = w_hs & (r_state == ST_SEND_TX);
    assign w_pop_rx = w_hs & (r_state == ST_SEND_RX);

    // A full queue still accepts a push when it pops on the same edge.
    assign w_push_tx = w_tx_req & ((r_tx_count != c_full) | w_pop_tx);
    assign w_push_rx = w_rx_req & ((r_rx_count != c_full) | w_pop_rx);

    assign w_err_inc  = ((opcode_in == c_op_send) | (opcode_in == c_op_recv)) & soft_error_in;
    assign w_drop_inc = (w_tx_req & ~w_push_tx) | (w_rx_req & ~w_push_rx);

    // Words left after this edge's pop, ignoring this edge's push (no bypass).
    assign w_tx_avail = (r_tx_count != (c_aw + 1)'(w_pop_tx));
    assign w_rx_avail = (r_rx_count != (c_aw + 1)'(w_pop_rx));
    assign w_tx_hidx  = r_tx_rptr + c_aw'(w_pop_tx);
    assign w_rx_hidx  = r_rx_rptr + c_aw'(w_pop_rx);

    always_ff @(posedge clk) begin
        if (w_push_tx) begin
            r_tx_mem[r_tx_wptr] <= tx_data_in;
        end
        if (w_push_rx) begin
            r_rx_mem_data[r_rx_wptr] <= rx_data_in;
            r_rx_mem_tag[r_rx_wptr]  <= rx_tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            r_tx_wptr  <= r_tx_wptr + c_aw'(w_push_tx);
            r_tx_rptr  <= r_tx_rptr + c_aw'(w_pop_tx);
            r_tx_count <= r_tx_count + (c_aw + 1)'(w_push_tx) - (c_aw + 1)'(w_pop_tx);
            r_rx_wptr  <= r_rx_wptr + c_aw'(w_push_rx);
            r_rx_rptr  <= r_rx_rptr + c_aw'(w_pop_rx);
            r_rx_count <= r_rx_count + (c_aw + 1)'(w_push_rx) - (c_aw + 1)'(w_pop_rx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_local_tag  <= '0;
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (cfg_tag_we) begin
                r_local_tag <= cfg_tag_in;
            end
            if (w_err_inc && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_drop_inc && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_prefer_rx <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_out_tag   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_prefer_rx <= w_prefer_rx_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_data  <= w_data_nxt;
            r_out_src   <= w_src_nxt;
            r_out_tag   <= w_tag_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_out_valid;
        w_data_nxt      = r_out_data;
        w_src_nxt       = r_out_src;
        w_tag_nxt       = r_out_tag;
        w_prefer_rx_nxt = r_prefer_rx;
        w_pick          = 1'b0;
        w_grant_rx      = 1'b0;
        w_grant_tx      = 1'b0;

        case (r_state)
            ST_IDLE:    w_pick = 1'b1;
            ST_SEND_TX: w_pick = w_hs;
            ST_SEND_RX: w_pick = w_hs;
            default:    w_pick = 1'b1;
        endcase

        // The queue just served loses priority to the other one.
        if (w_hs) begin
            w_prefer_rx_nxt = (r_state == ST_SEND_TX);
        end

        if (w_flush) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_src_nxt   = 1'b0;
            w_tag_nxt   = '0;
        end else if (w_pick) begin
            w_grant_rx = w_rx_avail & (~w_tx_avail | w_prefer_rx_nxt);
            w_grant_tx = w_tx_avail & ~w_grant_rx;
            if (w_grant_tx) begin
                w_state_nxt = ST_SEND_TX;
                w_valid_nxt = 1'b1;
                w_data_nxt  = r_tx_mem[w_tx_hidx];
                w_src_nxt   = 1'b0;
                w_tag_nxt   = '0;
            end else if (w_grant_rx) begin
                w_state_nxt = ST_SEND_RX;
                w_valid_nxt = 1'b1;
                w_data_nxt  = r_rx_mem_data[w_rx_hidx];
                w_src_nxt   = 1'b1;
                w_tag_nxt   = r_rx_mem_tag[w_rx_hidx];
            end else begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
                w_src_nxt   = 1'b0;
                w_tag_nxt   = '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign out_tag    = r_out_tag;
    assign tx_count   = r_tx_count;
    assign rx_count   = r_rx_count;
    assign err_count  = r_err_count;
    assign drop_count = r_drop_count;
    assign busy       = r_out_valid | (r_tx_count != '0) | (r_rx_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_asp_path_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_asp_path_scheduler                                         |
// | Brief    : Directed + random bench for asp_path_scheduler against a      |
// |            queue-level reference model.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_asp_path_scheduler;

    localparam int DW    = 32;
    localparam int TW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam logic [1:0] NOP = 2'b00, SEND = 2'b01, RECV = 2'b10, FLUSH = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    opcode_in;
    logic          soft_error_in;
    logic [DW-1:0] tx_data_in, rx_data_in;
    logic [TW-1:0] rx_tag_in, cfg_tag_in;
    logic          cfg_tag_we;
    logic          out_valid, out_ready, out_src, busy;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic [2:0]    tx_count, rx_count;
    logic [CW-1:0] err_count, drop_count;

    always #5 clk = ~clk;

    asp_path_scheduler #(.DATA_SIZE(DW), .TAG_SIZE(TW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode_in(opcode_in), .soft_error_in(soft_error_in),
        .tx_data_in(tx_data_in), .rx_data_in(rx_data_in), .rx_tag_in(rx_tag_in),
        .cfg_tag_we(cfg_tag_we), .cfg_tag_in(cfg_tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .out_tag(out_tag),
        .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count),
        .drop_count(drop_count), .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queues plus the word currently offered downstream.
    logic [DW-1:0] m_txq[$];
    logic [DW-1:0] m_rxd[$];
    logic [TW-1:0] m_rxt[$];
    logic          m_valid, m_src, m_last_rx;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_otag, m_tag;
    int            m_err, m_drop;
    logic [DW-1:0] seen[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_txq.delete(); m_rxd.delete(); m_rxt.delete();
        m_valid = 1'b0; m_src = 1'b0; m_data = '0; m_otag = '0;
        m_last_rx = 1'b1; m_tag = '0; m_err = 0; m_drop = 0;
    endtask

    task automatic model_edge();
        logic hs;
        if (reset) begin
            model_clear();
            return;
        end
        hs = m_valid && out_ready;
        if (hs) begin
            if (!m_src) void'(m_txq.pop_front());
            else begin
                void'(m_rxd.pop_front());
                void'(m_rxt.pop_front());
            end
            m_last_rx = m_src;
        end
        if (opcode_in == FLUSH) begin
            m_txq.delete(); m_rxd.delete(); m_rxt.delete();
            m_valid = 1'b0;
        end else begin
            if (!m_valid || hs) begin
                if (m_txq.size() != 0 && (m_rxd.size() == 0 || m_last_rx)) begin
                    m_valid = 1'b1; m_src = 1'b0; m_data = m_txq[0]; m_otag = '0;
                end else if (m_rxd.size() != 0) begin
                    m_valid = 1'b1; m_src = 1'b1; m_data = m_rxd[0]; m_otag = m_rxt[0];
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (opcode_in == SEND || opcode_in == RECV) begin
                if (soft_error_in) begin
                    if (m_err < 255) m_err++;
                end else if (opcode_in == SEND) begin
                    if (m_txq.size() < DEPTH) m_txq.push_back(tx_data_in);
                    else if (m_drop < 255) m_drop++;
                end else if (rx_tag_in == m_tag) begin
                    if (m_rxd.size() < DEPTH) begin
                        m_rxd.push_back(rx_data_in);
                        m_rxt.push_back(rx_tag_in);
                    end else if (m_drop < 255) m_drop++;
                end
            end
        end
        if (cfg_tag_we) m_tag = cfg_tag_in;
    endtask

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_src", 64'(out_src), 64'(m_src));
            chk("out_tag", 64'(out_tag), 64'(m_otag));
        end
        chk("tx_count", 64'(tx_count), 64'(m_txq.size()));
        chk("rx_count", 64'(rx_count), 64'(m_rxd.size()));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("busy", 64'(busy), 64'(m_valid || m_txq.size() != 0 || m_rxd.size() != 0));
    endtask

    task automatic drive(input logic [1:0] op, input logic se, input logic [DW-1:0] txd,
                         input logic [DW-1:0] rxd, input logic [TW-1:0] rtag, input logic rdy);
        reset = 1'b0; opcode_in = op; soft_error_in = se; tx_data_in = txd;
        rx_data_in = rxd; rx_tag_in = rtag; out_ready = rdy; cfg_tag_we = 1'b0; cfg_tag_in = '0;
    endtask

    task automatic tick();
        if (!reset && out_valid && out_ready) seen.push_back(out_data);
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        model_clear();
        drive(NOP, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_src_tag", 64'({out_src, out_tag}), 64'd0);
        chk("rst_counts", 64'({tx_count, rx_count, err_count, drop_count, busy}), 64'd0);

        // Single TX word: visible two edges after the SEND, gone after the handshake.
        drive(SEND, 0, 32'hDEADBEEF, 0, 0, 1); tick();
        drive(NOP, 0, 0, 0, 0, 1); tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hDEADBEEF);
        chk("t1_src_tag", 64'({out_src, out_tag}), 64'd0);
        tick();
        chk("t1_txcnt", 64'(tx_count), 64'd0);
        chk("t1_valid_low", 64'(out_valid), 64'd0);

        // Tag filtering.
        drive(NOP, 0, 0, 0, 0, 1); cfg_tag_we = 1'b1; cfg_tag_in = 8'h5A; tick();
        drive(RECV, 0, 0, 32'h11111111, 8'h5A, 1); tick();
        drive(RECV, 0, 0, 32'h22222222, 8'h33, 1); tick();
        chk("t2_data", 64'(out_data), 64'h11111111);
        chk("t2_src_tag", 64'({out_src, out_tag}), 64'h15A);
        chk("t2_rxcnt", 64'(rx_count), 64'd1);
        drive(NOP, 0, 0, 0, 0, 1); tick(); tick(); tick();
        chk("t2_idle", 64'({out_valid, rx_count}), 64'd0);

        // Round-robin ordering with stalled downstream.
        seen.delete();
        drive(SEND, 0, 32'hA1, 0, 0, 0); tick();
        drive(SEND, 0, 32'hA2, 0, 0, 0); tick();
        drive(RECV, 0, 0, 32'hB1, 8'h5A, 0); tick();
        drive(RECV, 0, 0, 32'hB2, 8'h5A, 0); tick();
        drive(NOP, 0, 0, 0, 0, 0); tick(); tick();
        chk("t3_hold", 64'(out_data), 64'hA1);
        drive(NOP, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("t3_n", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) begin
            chk("t3_o0", 64'(seen[0]), 64'hA1);
            chk("t3_o1", 64'(seen[1]), 64'hB1);
            chk("t3_o2", 64'(seen[2]), 64'hA2);
            chk("t3_o3", 64'(seen[3]), 64'hB2);
        end

        // Overflow and soft-error drop.
        for (int i = 0; i < 6; i++) begin
            drive(SEND, 0, 32'h40 + i, 0, 0, 0); tick();
        end
        chk("t4_txcnt", 64'(tx_count), 64'd4);
        chk("t4_drop", 64'(drop_count), 64'd2);
        drive(SEND, 1, 32'hBAD, 0, 0, 0); tick();
        chk("t4_err", 64'(err_count), 64'd1);
        chk("t4_txcnt2", 64'(tx_count), 64'd4);

        // FLUSH with a handshake on the same edge.
        seen.delete();
        drive(FLUSH, 0, 0, 0, 0, 1); tick();
        chk("t5_consumed", 64'(seen.size()), 64'd1);
        if (seen.size() == 1) chk("t5_word", 64'(seen[0]), 64'h40);
        chk("t5_state", 64'({out_valid, tx_count, rx_count, busy}), 64'd0);
        chk("t5_counters", 64'({err_count, drop_count}), 64'h0102);

        // Randomized traffic: first phase mostly ready, second mostly stalled.
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 300; i++) begin
                int r;
                logic [1:0] op;
                r  = $urandom_range(0, 15);
                op = (r == 0) ? FLUSH : (r <= 5) ? SEND : (r <= 10) ? RECV : NOP;
                drive(op, $urandom_range(0, 9) == 0, $urandom, $urandom,
                      ($urandom_range(0, 3) != 0) ? m_tag : 8'hC3,
                      (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 49) == 0) begin
                    cfg_tag_we = 1'b1;
                    cfg_tag_in = $urandom_range(0, 1) ? 8'h5A : 8'hA5;
                end
                tick();
            end
        end

        // Reset mid-stream, then counter saturation.
        drive(SEND, 0, 32'h77, 0, 0, 0); tick();
        drive(RECV, 0, 0, 32'h88, m_tag, 0); tick();
        drive(NOP, 0, 0, 0, 0, 0); reset = 1'b1; tick();
        chk("t6_rst", 64'({out_valid, out_src, out_tag, tx_count, rx_count, busy}), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_cnt", 64'({err_count, drop_count}), 64'd0);
        for (int i = 0; i < 300; i++) begin
            drive(SEND, 1, i, 0, 0, 1); tick();
        end
        chk("t6_err_sat", 64'(err_count), 64'd255);
        chk("t6_tx_empty", 64'(tx_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
